sec_timer_bank: RTL
===================

Name: sec_timer_bank

Overview:
- Bank of N_CH independent seconds-based countdown timers for the elevator controller: door-open hold, floor-travel timeout, idle-return.
- Successor to the single free-running seconds counter: adds parametrised width, tick period and channel count, per-channel start/cancel/expire handshake, exact first-second alignment.
- Sits between the elevator FSM (issues start/cancel) and display/timeout logic (consumes elapsed/expired).

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second tick; must be >= 2.
- SEC_W, 4: width of per-channel seconds count and duration.
- N_CH, 2: number of timer channels; must be >= 1.

Ports:
- clk  in  1  system clock.
- reseta  in  1  asynchronous active-high reset.
- start  in  N_CH  per-channel one-cycle start/restart request.
- cancel  in  N_CH  per-channel abort request.
- load_sec  in  N_CH*SEC_W  per-channel duration in seconds, sampled on start; channel i at bits [i*SEC_W +: SEC_W].
- elapsed  out  N_CH*SEC_W  whole seconds elapsed since last start, packed as load_sec.
- busy  out  N_CH  channel running.
- expired  out  N_CH  one-cycle pulse when the duration completes.

Behaviour:
- Reset: async on reseta=1, with no clock needed. All outputs become 0 immediately: elapsed, busy, expired. Prescalers go to 0, targets to 0, all FSMs to IDLE. Reset mid-run discards the run and emits no expired pulse.
- Prescaler (per channel):
  - Counter of width clog2(TICK_DIV), counting 0..TICK_DIV-1 while the channel is in RUN.
  - Held at 0 in IDLE. Synchronously cleared to 0 on an accepted start.
  - tick_i=1 when count==TICK_DIV-1 and the channel is in RUN; the counter then wraps to 0.
- Channel FSM, states IDLE and RUN:
  - IDLE, start=1, cancel=0, load_sec!=0: latch target=load_sec, elapsed=0, busy=1, go to RUN.
  - IDLE, start=1, load_sec==0: stay IDLE, elapsed=0, expired=1 for exactly one cycle on the next edge.
  - RUN, start=1, cancel=0: restart. Re-latch target, elapsed=0, prescaler=0, stay RUN. No expired pulse for the aborted run. Zero-duration restart behaves as in the IDLE case and goes to IDLE.
  - RUN, cancel=1: go to IDLE, busy=0, elapsed holds its value, no expired pulse.
  - start and cancel in the same cycle: cancel wins in every state.
  - RUN, tick_i and elapsed+1==target: elapsed=target, busy=0, expired=1 for one cycle, go to IDLE.
  - RUN, tick_i otherwise: elapsed+1.
- Latency:
  - start sampled at edge k gives busy=1 after edge k.
  - elapsed increments after edges k+TICK_DIV, k+2*TICK_DIV, and so on.
  - expired is high in the cycle after edge k+target*TICK_DIV.
- Width and overflow: max duration is 2^SEC_W-1. elapsed never exceeds target, so there is no wrap. Arithmetic is unsigned.
- Idle hold: elapsed holds its last value in IDLE until the next start. expired is registered and never high for 2 consecutive cycles.
- Independence: channels are fully independent; no shared state.

Optional Feature:
- Macro: SEC_TIMER_PAUSE_EN.
- Defined:
  - Adds input pause [N_CH].
  - While pause_i=1 in RUN, prescaler_i and elapsed_i freeze and busy stays 1.
  - cancel and start are still honoured during pause.
  - pause in IDLE has no effect.
- Undefined: port absent; channels always count while in RUN.

Decomposition:
- Package sec_timer_pkg: state enum (ST_IDLE, ST_RUN), default constants for TICK_DIV, SEC_W and N_CH, and a helper function computing the prescaler width.
- Sub-module tick_prescaler, parameter TICK_DIV. Ports: clk, reseta, en, clr, tick.
- One tick_prescaler per channel, instantiated in a generate loop alongside the per-channel FSM.

Test Plan (TICK_DIV=4, SEC_W=4, N_CH=2):
- Basic run: ch0 load_sec=3, start pulse at edge 0 -> busy0=1 from edge 0; elapsed0 = 1, 2, 3 after edges 4, 8, 12; expired0=1 for the single cycle after edge 12; busy0=0 then; elapsed0 holds 3.
- Cancel: ch1 load_sec=5, start, cancel at edge 9 -> busy1=0, elapsed1=2 held, expired1 never asserts.
- Restart plus conflict:
  - ch0 running with load 4, start with load_sec=2 at edge 6 -> elapsed0=0, expired after edge 14.
  - Simultaneous start+cancel -> IDLE, busy0=0.
- Zero duration: start with load_sec=0 -> expired=1 for one cycle, busy never rises. load_sec=15 -> expired after 60 cycles, elapsed=15, no wrap.
- Async reset: assert reseta mid-run between clock edges -> all outputs 0 immediately; no expired after release; a fresh start after release times correctly.
- Pause (SEC_TIMER_PAUSE_EN): load 2, pause held 10 cycles at elapsed=1 -> expired delayed by exactly 10 cycles versus the unpaused run.

Source files
------------

// File: rtl/sec_timer_bank_pkg.sv
// Shared types and defaults for the seconds timer bank.
// Optional pause support is enabled with the SEC_TIMER_PAUSE_EN macro (see interface/top).
package sec_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_TICK_DIV = 50000000;
  localparam int DEF_SEC_W    = 4;
  localparam int DEF_N_CH     = 2;

  // Prescaler counter width; never less than one bit.
  function automatic int presc_w(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sec_timer_bank_if.sv
// Control/status bundle between the elevator FSM (master) and the timer bank (slave).
// With SEC_TIMER_PAUSE_EN defined, a per-channel pause input is added.
//
// Handshake: start/cancel are single-cycle requests sampled on every rising
// clk edge (no ready; the bank always accepts). cancel wins over start.
// load_sec is sampled only in the cycle start is high. expired is a
// one-cycle registered pulse; busy/elapsed are level status.
interface sec_timer_bank_if #(
  parameter int N_CH  = 2,
  parameter int SEC_W = 4
);
  logic [N_CH-1:0]       start;
  logic [N_CH-1:0]       cancel;
  logic [N_CH*SEC_W-1:0] load_sec;
  logic [N_CH*SEC_W-1:0] elapsed;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       expired;
  // Debug view of each channel FSM: 1 = RUN, 0 = IDLE.
  logic [N_CH-1:0]       run_dbg;
`ifdef SEC_TIMER_PAUSE_EN
  logic [N_CH-1:0]       pause;
`endif

  modport master (
    output start, cancel, load_sec,
`ifdef SEC_TIMER_PAUSE_EN
    output pause,
`endif
    input  elapsed, busy, expired, run_dbg
  );

  modport slave (
    input  start, cancel, load_sec,
`ifdef SEC_TIMER_PAUSE_EN
    input  pause,
`endif
    output elapsed, busy, expired, run_dbg
  );
endinterface

// File: rtl/sec_timer_bank_tick_prescaler.sv
// One-second tick generator: counts 0..TICK_DIV-1 while enabled, pulses tick
// on the last count and wraps. clr forces the count back to zero.
module tick_prescaler
  import sec_timer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reseta,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = presc_w(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Free count while enabled, hold when frozen, zero on clear.
  always_ff @(posedge clk or posedge reseta) begin
    if (reseta) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/sec_timer_bank.sv
// Bank of N_CH independent countdown timers counting whole seconds.
// Define SEC_TIMER_PAUSE_EN to add a per-channel pause input that freezes a
// running channel.
module sec_timer_bank
  import sec_timer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int SEC_W    = DEF_SEC_W,
  parameter int N_CH     = DEF_N_CH
) (
  input logic             clk,
  input logic             reseta,
  sec_timer_bank_if.slave bus
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state;
    logic [SEC_W-1:0] target;
    logic [SEC_W-1:0] elapsed;
    logic             expired;
    logic [SEC_W-1:0] load;
    logic             req_start;
    logic             req_cancel;
    logic             hold;
    logic             run;
    logic             en;
    logic             clr;
    logic             tick;

    assign load       = bus.load_sec[i*SEC_W +: SEC_W];
    assign req_start  = bus.start[i];
    assign req_cancel = bus.cancel[i];
`ifdef SEC_TIMER_PAUSE_EN
    assign hold       = bus.pause[i];
`else
    assign hold       = 1'b0;
`endif
    assign run = (state == ST_RUN);
    assign en  = run && !hold;
    // Prescaler stays at zero in IDLE and restarts on any new request.
    assign clr = !run || req_start || req_cancel;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk    (clk),
      .reseta (reseta),
      .en     (en),
      .clr    (clr),
      .tick   (tick)
    );

    // Channel FSM: start/restart, cancel (wins over start), per-second count, expiry.
    always_ff @(posedge clk or posedge reseta) begin
      if (reseta) begin
        state   <= ST_IDLE;
        target  <= '0;
        elapsed <= '0;
        expired <= 1'b0;
      end else begin
        expired <= 1'b0;
        if (req_cancel) begin
          state <= ST_IDLE;
        end else if (req_start) begin
          elapsed <= '0;
          if (load == '0) begin
            state   <= ST_IDLE;
            // Keeps expired a single-cycle pulse even if start is held.
            expired <= !expired;
          end else begin
            state  <= ST_RUN;
            target <= load;
          end
        end else if (run && tick) begin
          if ((elapsed + SEC_W'(1)) == target) begin
            elapsed <= target;
            state   <= ST_IDLE;
            expired <= 1'b1;
          end else begin
            elapsed <= elapsed + SEC_W'(1);
          end
        end
      end
    end

    assign bus.elapsed[i*SEC_W +: SEC_W] = elapsed;
    assign bus.busy[i]    = run;
    assign bus.expired[i] = expired;
    assign bus.run_dbg[i] = run;
  end

endmodule
